// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-to-device transmitter:
//   - ps2_state_t : transmitter FSM states
//   - DEFAULT_*   : default timing and filter constants (65 MHz system clock)
//   - CMD_*       : commonly sent keyboard command bytes
//   - odd_parity  : parity bit that makes the 9-bit {parity, data} word odd
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQUEST,
      SEND,
      ACK,
      RELEASE
   } ps2_state_t;

   localparam int DEFAULT_INHIBIT_CYCLES = 6500;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1300000;
   localparam int DEFAULT_FILTER_LEN     = 8;

   localparam int EDGE_MAX = 11;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw PS/2 line into the clk domain and cleans it up.
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   line_in    in  raw asynchronous line level
//   line_sync  out line level after the 2-flop synchronizer
//   fall       out one-cycle pulse when the filtered level changes 1 -> 0
// A new level is accepted only after FILTER_LEN consecutive synchronized
// samples disagree with the current filtered level, so short glitches on the
// line never produce an edge.
// -----------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic line_sync,
   output logic fall
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync_meta;
   logic          line_filt;
   logic [FW-1:0] stable_cnt;

   // Synchronize, then count consecutive samples that differ from the
   // filtered level; the idle line level is high, so everything resets to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta  <= 1'b1;
         line_sync  <= 1'b1;
         line_filt  <= 1'b1;
         stable_cnt <= '0;
         fall       <= 1'b0;
      end else begin
         sync_meta <= line_in;
         line_sync <= sync_meta;
         fall      <= 1'b0;
         if (line_sync != line_filt) begin
            if (stable_cnt == FW'(FILTER_LEN - 1)) begin
               line_filt  <= line_sync;
               stable_cnt <= '0;
               fall       <= ~line_sync;
            end else begin
               stable_cnt <= stable_cnt + 1'b1;
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_tx.sv
// -----------------------------------------------------------------------------
// ps2_tx
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out 8 data bits (LSB first), odd parity and stop on device-generated
// falling clock edges, then checks the device acknowledge.
//   clk          in  system clock (65 MHz domain)
//   reset        in  synchronous, active-high reset
//   tx_data      in  command byte, sampled with tx_start
//   tx_start     in  single-cycle request, ignored while busy
//   ps2_clk_in   in  raw PS/2 clock line level
//   ps2_data_in  in  raw PS/2 data line level
//   ps2_clk_oe   out 1 = pull PS/2 clock low
//   ps2_data_oe  out 1 = pull PS/2 data low
//   busy         out transfer in progress
//   tx_done      out one-cycle pulse, byte acknowledged
//   tx_error     out one-cycle pulse, missing acknowledge (or watchdog)
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a per-transfer watchdog of
// TIMEOUT_CYCLES cycles that aborts the transfer and pulses tx_error.
// -----------------------------------------------------------------------------
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int FILTER_LEN     = DEFAULT_FILTER_LEN
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

   ps2_state_t    state;
   logic [8:0]    shift_reg;
   logic [IW-1:0] inhibit_cnt;
   logic [3:0]    edge_cnt;
   logic [3:0]    edge_next;
   logic          ack_ok;
   logic          clk_sync;
   logic          clk_fall;
   logic          data_meta;
   logic          data_sync;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_cnt;
`endif

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filter (
      .clk      (clk),
      .reset    (reset),
      .line_in  (ps2_clk_in),
      .line_sync(clk_sync),
      .fall     (clk_fall)
   );

   // The data line is only read for the acknowledge and the release check,
   // so a plain 2-flop synchronizer is enough.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   // Falling-edge count saturates so stray edges after the ack cannot wrap it.
   assign edge_next = (edge_cnt == 4'(EDGE_MAX)) ? edge_cnt : edge_cnt + 4'd1;

   // Transmitter FSM with registered line enables and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         inhibit_cnt <= '0;
         edge_cnt    <= '0;
         ack_ok      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd_cnt      <= '0;
`endif
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            IDLE: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
               edge_cnt    <= '0;
               inhibit_cnt <= '0;
`ifdef PS2_TX_TIMEOUT_EN
               wd_cnt      <= '0;
`endif
               if (tx_start) begin
                  shift_reg  <= {odd_parity(tx_data), tx_data};
                  state      <= INHIBIT;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
               end
            end
            INHIBIT: begin
               if (inhibit_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                  state       <= REQUEST;
                  ps2_data_oe <= 1'b1;
               end else begin
                  inhibit_cnt <= inhibit_cnt + 1'b1;
               end
            end
            REQUEST: begin
               // Start bit stays on the data line; the device now owns clock.
               ps2_clk_oe <= 1'b0;
               state      <= SEND;
            end
            SEND: begin
               if (clk_fall) begin
                  edge_cnt <= edge_next;
                  if (edge_cnt < 4'd9) begin
                     ps2_data_oe <= ~shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[8:1]};
                  end else begin
                     ps2_data_oe <= 1'b0;
                     state       <= ACK;
                  end
               end
            end
            ACK: begin
               if (clk_fall) begin
                  edge_cnt <= edge_next;
                  ack_ok   <= ~data_sync;
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               if (clk_sync && data_sync) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_done  <= ack_ok;
                  tx_error <= ~ack_ok;
               end
            end
            default: begin
               state       <= IDLE;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         // Watchdog overrides whatever the FSM chose this cycle.
         if (state != IDLE) begin
            if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
               state       <= IDLE;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               busy        <= 1'b0;
               tx_done     <= 1'b0;
               tx_error    <= 1'b1;
            end else begin
               wd_cnt <= wd_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule
